// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch timekeeping core: state encoding,
// BCD digit width and per-position digit radix.
package stopwatch_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [1:0] ST_PAUSED = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_ADJUST = 2'd2;

  // Positions 1 and 3 are tens-of-seconds / tens-of-minutes.
  function automatic int digit_radix(input int idx);
    return ((idx == 1) || (idx == 3)) ? 6 : 10;
  endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// Control/display bundle between the input conditioning logic, stopwatch_core
// and the 7-segment driver. LAP_EN adds btn_lap / lap_hold.
interface stopwatch_core_if #(
  parameter int NUM_DIGITS = 4,
  parameter int SEL_W      = 3
);

  logic                    tick;
  logic                    blink_tick;
  logic                    btn_reset;
  logic                    btn_pause;
  logic                    adj;
  logic [SEL_W-1:0]        sel;
  logic [3:0]              num;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    running;
  logic                    wrap;
`ifdef LAP_EN
  logic                    btn_lap;
  logic                    lap_hold;

  modport master (
    output tick, blink_tick, btn_reset, btn_pause, adj, sel, num, load, btn_lap,
    input  digits, blank, running, wrap, lap_hold
  );

  modport slave (
    input  tick, blink_tick, btn_reset, btn_pause, adj, sel, num, load, btn_lap,
    output digits, blank, running, wrap, lap_hold
  );
`else
  modport master (
    output tick, blink_tick, btn_reset, btn_pause, adj, sel, num, load,
    input  digits, blank, running, wrap
  );

  modport slave (
    input  tick, blink_tick, btn_reset, btn_pause, adj, sel, num, load,
    output digits, blank, running, wrap
  );
`endif

endinterface

// File: rtl/stopwatch_core_bcd_digit.sv
// Single BCD digit with configurable radix: synchronous clear, clamped load,
// and increment on carry-in with a combinational carry-out for rippling.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int RADIX = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               cin,
  output logic [DIGIT_W-1:0] q,
  output logic               cout
);

  localparam logic [DIGIT_W-1:0] MAX = DIGIT_W'(RADIX - 1);

  logic [DIGIT_W-1:0] val_q;
  logic [DIGIT_W-1:0] val_d;

  always_comb begin
    val_d = val_q;
    if (clr) begin
      val_d = '0;
    end else if (load) begin
      val_d = (load_val > MAX) ? MAX : load_val;
    end else if (cin) begin
      val_d = (val_q == MAX) ? '0 : val_q + DIGIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign q    = val_q;
  assign cout = cin && (val_q == MAX);

endmodule

// File: rtl/stopwatch_core.sv
// N-digit BCD stopwatch core: run/pause, clear, clamped per-digit adjust with
// blink mask, wrap pulse. Optional lap snapshot enabled by `define LAP_EN.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SEL_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_core_if.slave  bus
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       phase_q;
  logic       phase_d;
  logic       running_q;
  logic       running_d;
  logic       wrap_q;
  logic       wrap_d;

  logic                          clr;
  logic                          inc;
  logic                          ld;
  logic                          sel_ok;
  logic [NUM_DIGITS:0]           carry;
  logic [DIGIT_W*NUM_DIGITS-1:0] live;
  logic [NUM_DIGITS-1:0]         blank_mask;

  assign sel_ok = (int'(bus.sel) < NUM_DIGITS);

  // Priority: btn_reset > adj > btn_pause > tick; lower-priority events are dropped.
  always_comb begin
    state_d = state_q;
    clr     = bus.btn_reset;
    inc     = 1'b0;
    ld      = 1'b0;
    if (!bus.btn_reset) begin
      if (bus.adj) begin
        state_d = ST_ADJUST;
        ld      = bus.load && (state_q == ST_ADJUST) && sel_ok;
      end else if (state_q == ST_ADJUST) begin
        state_d = ST_PAUSED;
      end else if (bus.btn_pause) begin
        state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
      end else if (bus.tick && (state_q == ST_RUN)) begin
        inc = 1'b1;
      end
    end
    running_d = (state_d == ST_RUN);
    wrap_d    = carry[NUM_DIGITS];
    if ((state_q == ST_ADJUST) && (state_d == ST_ADJUST)) begin
      phase_d = phase_q ^ bus.blink_tick;
    end else begin
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_PAUSED;
      phase_q   <= 1'b0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
    end
  end

  assign carry[0] = inc;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit #(
      .RADIX(digit_radix(i))
    ) u_digit (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .load     (ld && (bus.sel == SEL_W'(i))),
      .load_val (bus.num),
      .cin      (carry[i]),
      .q        (live[DIGIT_W*i +: DIGIT_W]),
      .cout     (carry[i+1])
    );

    assign blank_mask[i] = phase_q && (bus.sel == SEL_W'(i));
  end

  assign bus.blank   = blank_mask;
  assign bus.running = running_q;
  assign bus.wrap    = wrap_q;

`ifdef LAP_EN
  logic                          lap_hold_q;
  logic                          lap_hold_d;
  logic [DIGIT_W*NUM_DIGITS-1:0] lap_q;
  logic [DIGIT_W*NUM_DIGITS-1:0] lap_d;

  always_comb begin
    lap_hold_d = lap_hold_q;
    lap_d      = lap_q;
    if (bus.btn_reset || (state_d != ST_RUN)) begin
      lap_hold_d = 1'b0;
    end else if (bus.btn_lap && (state_q == ST_RUN)) begin
      lap_hold_d = !lap_hold_q;
      if (!lap_hold_q) begin
        lap_d = live;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lap_hold_q <= 1'b0;
      lap_q      <= '0;
    end else begin
      lap_hold_q <= lap_hold_d;
      lap_q      <= lap_d;
    end
  end

  assign bus.digits   = lap_hold_q ? lap_q : live;
  assign bus.lap_hold = lap_hold_q;
`else
  assign bus.digits = live;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed self-checking bench for stopwatch_core (4 digits): vector table
// plus hand sequences for counting, wrap, blink, mid-run reset and lap.
module tb_stopwatch_core;

  logic clk;
  logic rst;

  stopwatch_core_if #(.NUM_DIGITS(4), .SEL_W(3)) bus ();

  stopwatch_core #(
    .NUM_DIGITS(4),
    .SEL_W(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  typedef struct {
    logic        adj;
    logic [2:0]  sel;
    logic [3:0]  num;
    logic        load;
    logic        btn_reset;
    logic        btn_pause;
    logic        tick;
    logic [15:0] exp_digits;
    logic        exp_running;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input logic adj, input logic [2:0] sel, input logic [3:0] num,
                              input logic load, input logic btn_reset, input logic btn_pause,
                              input logic tick, input logic [15:0] exp_digits,
                              input logic exp_running);
    vec_t v;
    v.adj = adj; v.sel = sel; v.num = num; v.load = load;
    v.btn_reset = btn_reset; v.btn_pause = btn_pause; v.tick = tick;
    v.exp_digits = exp_digits; v.exp_running = exp_running;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic adj, input logic [2:0] sel, input logic [3:0] num,
                        input logic load, input logic btn_reset, input logic btn_pause,
                        input logic tick, input logic blink);
    bus.adj        = adj;
    bus.sel        = sel;
    bus.num        = num;
    bus.load       = load;
    bus.btn_reset  = btn_reset;
    bus.btn_pause  = btn_pause;
    bus.tick       = tick;
    bus.blink_tick = blink;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef LAP_EN
    bus.btn_lap = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  task automatic chk_state(input string name, input logic [15:0] d, input logic [3:0] b,
                           input logic r, input logic w);
    chk({name, ".digits"},  32'(bus.digits),  32'(d));
    chk({name, ".blank"},   32'(bus.blank),   32'(b));
    chk({name, ".running"}, 32'(bus.running), 32'(r));
    chk({name, ".wrap"},    32'(bus.wrap),    32'(w));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle();

    // ---- reset values while rst held low ----
    rst = 1'b0;
    cyc();
    chk_state("reset", 16'h0000, 4'b0000, 1'b0, 1'b0);
    rst = 1'b1;

    //                adj sel  num   ld   bres bpau tick  digits    run
    vecs[0]  = mk(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    vecs[1]  = mk(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
    vecs[2]  = mk(1'b1, 3'd1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    vecs[3]  = mk(1'b1, 3'd1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0050, 1'b0);
    vecs[4]  = mk(1'b1, 3'd0, 4'd12, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0059, 1'b0);
    vecs[5]  = mk(1'b1, 3'd5, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0059, 1'b0);
    vecs[6]  = mk(1'b1, 3'd3, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 16'h5059, 1'b0);
    vecs[7]  = mk(1'b1, 3'd2, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 16'h5459, 1'b0);
    vecs[8]  = mk(1'b1, 3'd2, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    vecs[9]  = mk(1'b1, 3'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0);
    vecs[10] = mk(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0);
    vecs[11] = mk(1'b0, 3'd0, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0);
    vecs[12] = mk(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0003, 1'b1);
    vecs[13] = mk(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0004, 1'b1);
    vecs[14] = mk(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0004, 1'b0);
    vecs[15] = mk(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0004, 1'b0);
    vecs[16] = mk(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0004, 1'b1);
    vecs[17] = mk(1'b1, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0004, 1'b0);
    vecs[18] = mk(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0004, 1'b0);
    vecs[19] = mk(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0004, 1'b1);
    vecs[20] = mk(1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1);
    vecs[21] = mk(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1);
    vecs[22] = mk(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0);

    for (int i = 0; i < 23; i++) begin
      set_in(vecs[i].adj, vecs[i].sel, vecs[i].num, vecs[i].load,
             vecs[i].btn_reset, vecs[i].btn_pause, vecs[i].tick, 1'b0);
      cyc();
      chk_state($sformatf("vec%0d", i), vecs[i].exp_digits, 4'b0000, vecs[i].exp_running, 1'b0);
    end

    // ---- run 75 ticks -> 01:15 ----
    do_reset();
    set_in(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("count.start_running", 32'(bus.running), 32'd1);
    set_in(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 75; i++) cyc();
    idle();
    chk_state("count75", 16'h0115, 4'b0000, 1'b1, 1'b0);

    // ---- rst mid-run overrides everything ----
    set_in(1'b1, 3'd2, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    cyc();
    chk_state("midrst", 16'h0000, 4'b0000, 1'b0, 1'b0);
    rst = 1'b1;
    idle();

    // ---- preload 59:59 and wrap ----
    set_in(1'b1, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 3'(i), ((i % 2) == 1) ? 4'd5 : 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
    end
    chk("wrap.preload", 32'(bus.digits), 32'h5959);
    idle();
    cyc();
    set_in(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    chk_state("wrap.pre", 16'h5959, 4'b0000, 1'b1, 1'b0);
    set_in(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc();
    chk_state("wrap.roll", 16'h0000, 4'b0000, 1'b1, 1'b1);
    idle();
    cyc();
    chk_state("wrap.after", 16'h0000, 4'b0000, 1'b1, 1'b0);

    // ---- blink in ADJUST, sel=2 ----
    set_in(1'b1, 3'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    chk_state("blink.enter", 16'h0000, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 3'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc();
      chk($sformatf("blink.tick%0d", i), 32'(bus.blank), (i % 2 == 0) ? 32'h4 : 32'h0);
      set_in(1'b1, 3'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
      chk($sformatf("blink.hold%0d", i), 32'(bus.blank), (i % 2 == 0) ? 32'h4 : 32'h0);
    end
    set_in(1'b1, 3'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    chk("blink.on", 32'(bus.blank), 32'h4);
    idle();
    cyc();
    chk_state("blink.exit", 16'h0000, 4'b0000, 1'b0, 1'b0);
    set_in(1'b1, 3'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("blink.phase_cleared", 32'(bus.blank), 32'h0);
    idle();
    cyc();
    set_in(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("blink.paused_then_run", 32'(bus.running), 32'd1);
    idle();

`ifdef LAP_EN
    // ---- lap snapshot ----
    do_reset();
    set_in(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    set_in(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cyc();
    idle();
    chk("lap.pre", 32'(bus.digits), 32'h0010);
    bus.btn_lap = 1'b1;
    cyc();
    bus.btn_lap = 1'b0;
    chk("lap.hold_set", 32'(bus.lap_hold), 32'd1);
    set_in(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc();
    idle();
    chk("lap.frozen", 32'(bus.digits), 32'h0010);
    chk("lap.hold", 32'(bus.lap_hold), 32'd1);
    bus.btn_lap = 1'b1;
    cyc();
    bus.btn_lap = 1'b0;
    chk("lap.release", 32'(bus.digits), 32'h0015);
    chk("lap.hold_clr", 32'(bus.lap_hold), 32'd0);
    bus.btn_lap = 1'b1;
    cyc();
    bus.btn_lap = 1'b0;
    chk("lap.hold_again", 32'(bus.lap_hold), 32'd1);
    set_in(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    idle();
    chk("lap.pause_clr", 32'(bus.lap_hold), 32'd0);
    chk("lap.pause_running", 32'(bus.running), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
Parametrised BCD timekeeping core for the stopwatch: an N-digit mm:ss-style counter with run/pause, synchronous clear, per-digit adjust with clamp, and an adjust-mode blink mask. It replaces the fixed 4-digit counter path. It sits between the clock divider and debouncers on the input side and the 7-segment display driver on the output side. It consumes one-cycle enable pulses and runs entirely on the system clock.

Parameters:
NUM_DIGITS, 4, number of BCD digits (2..8); digit 0 is least significant.
SEL_W, 3, width of the digit-select input; must satisfy 2**SEL_W >= NUM_DIGITS.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  synchronous active-low reset, sampled on rising clk.
tick  input  1  count-enable pulse, one clk wide, at 1 Hz.
blink_tick  input  1  blink-rate pulse, one clk wide, at 5 Hz.
btn_reset  input  1  debounced clear request, single-cycle pulse.
btn_pause  input  1  debounced run/pause toggle, single-cycle pulse.
adj  input  1  level; 1 = adjust mode.
sel  input  SEL_W  digit index to adjust.
num  input  4  BCD value to load.
load  input  1  pulse; writes num into digit sel while in adjust mode.
digits  output  4*NUM_DIGITS  packed BCD; digit i is at [4i+3:4i].
blank  output  NUM_DIGITS  per-digit blank mask for the display driver.
running  output  1  high in RUN state.
wrap  output  1  one-cycle pulse when the count rolls from all-max to zero.

Behaviour:
- Digit radix: indices 1 and 3 use radix 6 (tens of seconds/minutes). All other indices use radix 10. Max value of a digit = radix-1.
- States: PAUSED, RUN, ADJUST. Reset state: PAUSED.
- Reset (rst==0): digits=0, blank=0, running=0, wrap=0, blink phase=0.
- Priority each cycle, highest first: rst, btn_reset, adj, btn_pause, tick.
- btn_reset: all digits become 0 next cycle; state is unchanged.
- adj==1: enter or stay in ADJUST from any state. adj falling (1->0): go to PAUSED.
- PAUSED + btn_pause -> RUN. RUN + btn_pause -> PAUSED. btn_pause is ignored in ADJUST.
- RUN + tick: increment with a full ripple carry in the same cycle. Digits are registered, so latency is 1 clk from the tick sample. A digit at max becomes 0 and carries into the next digit.
- Wrap: if all digits are at max when the tick arrives, all digits become 0 and wrap pulses high for exactly 1 clk.
- tick is ignored in PAUSED and ADJUST. A tick in the same cycle as btn_reset or btn_pause is dropped.
- ADJUST + load: digit[sel] <= min(num, radix(sel)-1). Examples: num=9 on a radix-6 digit stores 5; num>=10 on a radix-10 digit stores 9.
- load is ignored if sel>=NUM_DIGITS or if not in ADJUST.
- Blink: in ADJUST, the blink phase toggles on each blink_tick. blank = phase ? (1<<sel) : 0. Outside ADJUST, blank=0 and phase is held at 0.
- running = (state==RUN), registered.
- Any mid-operation rst returns to reset values on the next edge, regardless of other inputs.

Optional Feature:
LAP_EN: when defined, adds input btn_lap (pulse) and output lap_hold (1).
- RUN + btn_lap: snapshot the counter into a lap register and set lap_hold=1.
- While lap_hold=1, digits shows the snapshot; the live count keeps advancing internally.
- A second btn_lap, btn_reset, leaving RUN, or rst clears lap_hold; digits then shows the live count the next cycle.
- Without LAP_EN: no port, no lap register, and digits always shows the live count.

Decomposition:
- Package stopwatch_pkg holds:
  - state encoding (ST_PAUSED, ST_RUN, ST_ADJUST);
  - BCD width constant DIGIT_W=4;
  - function digit_radix(idx) returning 6 or 10.
- One natural sub-module: bcd_digit. It holds a single digit with a radix parameter, carry-in, carry-out, synchronous clear, and clamped load. It is instantiated NUM_DIGITS times in a generate loop.

Test Plan:
- Reset, then btn_pause, then 75 ticks -> running=1, digits=16'h0115 (01:15).
- Preload 59:59 via adjust, exit adj, btn_pause, 1 tick -> digits=16'h0000, wrap high for exactly 1 clk.
- adj=1, sel=1, num=9, load -> digit1=5; sel=0, num=12, load -> digit0=9; sel=5, load -> no change.
- ADJUST with sel=2 and 4 blink_ticks -> blank toggles between 4'b0100 and 4'b0000 on each tick; adj=0 -> blank=0 and state PAUSED.
- RUN with btn_pause and tick in the same cycle -> PAUSED, digits unchanged. btn_reset with adj=1 -> digits=0, state stays ADJUST.
- LAP_EN: RUN at 00:10, btn_lap, 5 ticks -> digits=16'h0010 and lap_hold=1; second btn_lap -> digits=16'h0015 and lap_hold=0.
